// File: rtl/sram_mem_ctrl.sv
// sram_mem_ctrl: splits 32-bit MEM-stage loads/stores into two 16-bit async SRAM accesses (low half first).
// Define SRAM_READ_BUF_EN to add a one-entry read buffer that short-circuits repeated loads.
module sram_mem_ctrl #(
    parameter logic [31:0] BASE_ADDR     = 32'd1024,
    parameter int          ACCESS_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_r_en,
    input  logic        mem_w_en,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        ready,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N,
    output logic        SRAM_WE_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] RD_LO = 3'd1;
    localparam logic [2:0] RD_HI = 3'd2;
    localparam logic [2:0] WR_LO = 3'd3;
    localparam logic [2:0] WR_HI = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;
    localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(ACCESS_CYCLES - 1);

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [16:0]   word_q, word_in;
    logic [31:0]   wdata_q, rdata_q;
    logic          rd, wr, hi, busy, last, hit;

    assign word_in = 17'((mem_addr - BASE_ADDR) >> 2);
    assign rd      = (state_q == RD_LO) | (state_q == RD_HI);
    assign wr      = (state_q == WR_LO) | (state_q == WR_HI);
    assign hi      = (state_q == RD_HI) | (state_q == WR_HI);
    assign busy    = rd | wr;
    assign last    = busy & (cnt_q == LAST);

`ifdef SRAM_READ_BUF_EN
    logic        buf_v_q;
    logic [16:0] buf_tag_q;
    logic [31:0] buf_data_q;
    assign hit = buf_v_q & (buf_tag_q == word_in) & mem_r_en & ~mem_w_en;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_v_q    <= 1'b0;
            buf_tag_q  <= '0;
            buf_data_q <= '0;
        end else if (state_q == RD_HI && last) begin
            buf_v_q    <= 1'b1;
            buf_tag_q  <= word_q;
            buf_data_q <= {SRAM_DQ, rdata_q[15:0]};
        end else if (state_q == WR_HI && last && buf_v_q && buf_tag_q == word_q) begin
            buf_data_q <= wdata_q;
        end
    end
`else
    assign hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = mem_w_en ? WR_LO : hit ? DONE : mem_r_en ? RD_LO : IDLE;
            RD_LO:   state_d = last ? RD_HI : RD_LO;
            RD_HI:   state_d = last ? DONE : RD_HI;
            WR_LO:   state_d = last ? WR_HI : WR_LO;
            WR_HI:   state_d = last ? DONE : WR_HI;
            default: state_d = IDLE;
        endcase
        cnt_d = (state_d != state_q || !busy) ? '0 : cnt_q + CW'(1);
    end

    // Address/data are captured every IDLE cycle, so the values of the entry cycle are held throughout.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            word_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == IDLE) begin
                word_q  <= word_in;
                wdata_q <= mem_wdata;
            end
            if (state_q == RD_LO && last) rdata_q[15:0] <= SRAM_DQ;
            if (state_q == RD_HI && last) rdata_q[31:16] <= SRAM_DQ;
`ifdef SRAM_READ_BUF_EN
            if (state_q == IDLE && state_d == DONE) rdata_q <= buf_data_q;
`endif
        end
    end

    assign SRAM_DQ   = wr ? (hi ? wdata_q[31:16] : wdata_q[15:0]) : 16'hzzzz;
    assign SRAM_ADDR = busy ? {word_q, hi} : 18'd0;
    assign SRAM_CE_N = ~busy;
    assign SRAM_UB_N = ~busy;
    assign SRAM_LB_N = ~busy;
    assign SRAM_OE_N = ~rd;
    assign SRAM_WE_N = ~wr;
    assign mem_rdata = rdata_q;
    assign ready     = ~((mem_r_en | mem_w_en) & (state_q != DONE));
endmodule

// File: doc/sram_mem_ctrl.md
Name: sram_mem_ctrl

Overview:
- Bridges the CPU MEM stage (32-bit word loads/stores) and the external 16-bit asynchronous SRAM bus.
- Each 32-bit access is split into two sequential 16-bit SRAM accesses: low half first, then high half.
- While an access is in progress it holds ready low, which the pipeline uses to freeze all stages.
- Sits directly between the MEM stage of the ARM core and the SRAM model/pins.

Parameters:
- BASE_ADDR, 1024: byte address that maps to SRAM word 0; subtracted from mem_addr.
- ACCESS_CYCLES, 2: clock cycles each 16-bit half-access is held on the bus (min 1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- mem_r_en  input  1  load request from MEM stage.
- mem_w_en  input  1  store request from MEM stage.
- mem_addr  input  32  byte address, word aligned.
- mem_wdata  input  32  store data.
- mem_rdata  output  32  load data; valid when ready=1 after a load.
- ready  output  1  0 = freeze pipeline; 1 = no access pending or access complete.
- SRAM_DQ  inout  16  SRAM data bus.
- SRAM_ADDR  output  18  SRAM half-word address.
- SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N  output  1 each  active-low SRAM controls.

Behaviour:
- Address mapping:
  - word = (mem_addr - BASE_ADDR) >> 2, 32-bit subtract.
  - Low-half SRAM_ADDR = {word[16:0],1'b0}; high-half = {word[16:0],1'b1}.
  - Upper bits are truncated; the address wraps silently and there is no error signal.
- FSM states: IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE.
- From IDLE:
  - mem_w_en=1 -> WR_LO. mem_w_en has priority when both enables are high.
  - Otherwise mem_r_en=1 -> RD_LO.
  - Otherwise remain in IDLE.
- Each LO/HI state lasts exactly ACCESS_CYCLES cycles, timed by an internal counter that clears on every state change.
- Transitions: RD_LO -> RD_HI -> DONE; WR_LO -> WR_HI -> DONE.
- DONE lasts one cycle, then returns to IDLE. Enables are not sampled in DONE.
- Read path:
  - SRAM_DQ is sampled on the last cycle of RD_LO into mem_rdata[15:0], and on the last cycle of RD_HI into mem_rdata[31:16].
  - mem_rdata is registered and holds its value until the next load completes.
- Write path:
  - SRAM_DQ = mem_wdata[15:0] during WR_LO and mem_wdata[31:16] during WR_HI.
  - mem_addr and mem_wdata are latched on entry from IDLE; input changes mid-access are ignored.
- SRAM_DQ is high-Z in every state except WR_LO and WR_HI.
- Controls during LO/HI states:
  - SRAM_CE_N=0, SRAM_UB_N=0, SRAM_LB_N=0.
  - SRAM_OE_N=0 in RD states only; SRAM_WE_N=0 in WR states only.
- Controls in IDLE and DONE: all five _N outputs = 1.
- ready (combinational) = ~((mem_r_en | mem_w_en) & (state != DONE)).
  - ready=1 in IDLE with no request.
  - ready=1 in DONE.
- Latency: ready rises 2*ACCESS_CYCLES+1 cycles after the request is first seen in IDLE (5 cycles at default).
- Back-to-back: a request still asserted in the cycle after DONE starts a new access from IDLE. The pipeline has advanced by then, so this is the next instruction's request.
- Reset (rst=0, asynchronous, may occur mid-access):
  - state=IDLE, counter=0, mem_rdata=0.
  - All _N outputs = 1, SRAM_ADDR=0, SRAM_DQ high-Z.
  - Any partial write already committed to the low half stays in SRAM.

Optional Feature:
- Macro: SRAM_READ_BUF_EN.
- Defined: adds a one-entry read buffer holding a tag (latched word address), 32-bit data and a valid bit.
  - A load whose word matches a valid tag goes IDLE -> DONE directly: 1-cycle freeze, no SRAM bus activity.
  - Every completed load fills the buffer.
  - Any store to the same word updates the buffer data; a store to any other word leaves the buffer unchanged.
  - Reset clears the valid bit.
- Undefined: every load performs both SRAM half accesses; no buffer registers are instantiated.

Test Plan:
- Reset: hold rst=0 mid-RD_LO -> state IDLE immediately, all _N=1, DQ high-Z, mem_rdata=0, ready=1.
- Store/load round trip: store 0xDEADBEEF to 1024 -> SRAM[0]=0xBEEF, SRAM[1]=0xDEAD; ready low 5 cycles. Then load 1024 -> mem_rdata=0xDEADBEEF on the DONE cycle.
- Address mapping: store 0x12345678 to 1036 -> SRAM_ADDR sequence 6 then 7. Load 1036 returns 0x12345678.
- Simultaneous enables: mem_r_en=mem_w_en=1 at 1028 with data 0xA5A5_5A5A -> write performed; SRAM_WE_N pulses and SRAM_OE_N stays 1.
- Back-to-back loads at 1024 then 1028 -> two full 5-cycle freezes; the second mem_rdata is correct; DQ never driven by the controller.
- With SRAM_READ_BUF_EN defined: load 1024 twice -> second load has ready low 1 cycle and no CE_N activity. Store 0x0 to 1024, then load -> returns 0x0.
